// File: rtl/decoder_seq_nx2n.sv
// Registered N-to-2^N one-hot decoder with enable, valid/ready select input
// and an autonomous scan mode. Scan mode walks the one-hot output over every
// line, holding each line for DWELL cycles and pulsing wrap on the return to
// line 0. Every output except sel_ready comes straight from a flop, so the
// select lines it drives are glitch-free.
module decoder_seq_nx2n #(
  parameter  int SEL_W = 2,
  parameter  int DWELL = 4,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             sel_valid,
  output logic             sel_ready,
  output logic [OUT_W-1:0] dec_out,
  output logic             out_valid,
  output logic [SEL_W-1:0] cur_sel,
  output logic             wrap
);

  // The dwell counter needs at least one bit, even when DWELL is 1.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(OUT_W - 1);

  // Reject parameter values that cannot describe a working decoder.
  if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
    $error("decoder_seq_nx2n: DWELL must be within 1..65535");
  end
  if (SEL_W < 1) begin : g_bad_sel_w
    $error("decoder_seq_nx2n: SEL_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // outputs inactive, waiting for en
    ST_HOLD = 2'd1,  // direct-decode (or frozen scan) output held
    ST_SCAN = 2'd2   // auto-walk through all lines
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] dec_q, dec_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             transfer;
  logic [SEL_W-1:0] sel_next;

  // Standard one-hot mapping: bit i is set only when idx equals i.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_W; i++) begin
      r[i] = (idx == SEL_W'(i));
    end
    return r;
  endfunction

  // Selections are accepted only when enabled, in direct mode and not in SCAN.
  // Using the registered state means sel_ready stays low during the cycle in
  // which mode falls while scanning, and rises once the block has left SCAN.
  always_comb begin
    sel_ready = en & ~mode & (state_q != ST_SCAN);
  end

  assign transfer = sel_valid & sel_ready;

  // Next scan line. This relies on natural modulo-2**SEL_W overflow.
  assign sel_next = cur_sel_q + SEL_W'(1);

  // Next-state and next-output logic. en has top priority, then mode, then a
  // transfer or a scan advance.
  always_comb begin
    // NOTE: every _d gets a default first so that no path through the
    // branches below leaves a variable unassigned and infers a latch.
    state_d   = state_q;
    dec_d     = dec_q;
    valid_d   = valid_q;
    cur_sel_d = cur_sel_q;
    wrap_d    = 1'b0;
    cnt_d     = '0;

    if (!en) begin
      // Disable: blank the output. cur_sel keeps the last selected line.
      state_d = ST_IDLE;
      dec_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (mode) begin
            // Enter scan. It always starts at line 0 without a wrap pulse.
            state_d   = ST_SCAN;
            cur_sel_d = '0;
            dec_d     = onehot('0);
            valid_d   = 1'b1;
          end else if (transfer) begin
            state_d   = ST_HOLD;
            cur_sel_d = sel_in;
            dec_d     = onehot(sel_in);
            valid_d   = 1'b1;
          end
        end

        ST_SCAN: begin
          if (!mode) begin
            // Leave scan and freeze the line that is currently selected.
            state_d = ST_HOLD;
          end else if (cnt_q == CNT_LAST) begin
            // Dwell expired: step to the next line. wrap flags the return to 0.
            cur_sel_d = sel_next;
            dec_d     = onehot(sel_next);
            wrap_d    = (cur_sel_q == SEL_LAST);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          // An encoding that should never occur: recover to a quiet IDLE.
          state_d = ST_IDLE;
          dec_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers. rst_n is asynchronous, so the outputs clear
  // as soon as it falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments. Every register then
    // samples values from before the edge, whatever order they are written in.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dec_q     <= '0;
      valid_q   <= 1'b0;
      cur_sel_q <= '0;
      wrap_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dec_q     <= dec_d;
      valid_q   <= valid_d;
      cur_sel_q <= cur_sel_d;
      wrap_q    <= wrap_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dec_out   = dec_q;
  assign out_valid = valid_q;
  assign cur_sel   = cur_sel_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_seq_nx2n.sv
// Directed bench for decoder_seq_nx2n. Instance A (SEL_W=2, DWELL=3) covers
// reset, direct decode, scan, mode switch, enable priority and mid-run reset.
// Instance B (SEL_W=4, DWELL=1) sweeps the wide scan one line per cycle.
module tb_decoder_seq_nx2n;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: SEL_W=2, DWELL=3
  logic       a_en, a_mode, a_sel_valid, a_sel_ready, a_out_valid, a_wrap;
  logic [1:0] a_sel_in, a_cur_sel;
  logic [3:0] a_dec_out;

  // Instance B: SEL_W=4, DWELL=1
  logic        b_en, b_mode, b_sel_valid, b_sel_ready, b_out_valid, b_wrap;
  logic [3:0]  b_sel_in, b_cur_sel;
  logic [15:0] b_dec_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder_seq_nx2n #(.SEL_W(2), .DWELL(3)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (a_en),
    .mode      (a_mode),
    .sel_in    (a_sel_in),
    .sel_valid (a_sel_valid),
    .sel_ready (a_sel_ready),
    .dec_out   (a_dec_out),
    .out_valid (a_out_valid),
    .cur_sel   (a_cur_sel),
    .wrap      (a_wrap)
  );

  decoder_seq_nx2n #(.SEL_W(4), .DWELL(1)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (b_en),
    .mode      (b_mode),
    .sel_in    (b_sel_in),
    .sel_valid (b_sel_valid),
    .sel_ready (b_sel_ready),
    .dec_out   (b_dec_out),
    .out_valid (b_out_valid),
    .cur_sel   (b_cur_sel),
    .wrap      (b_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle 1 ns past the edge before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int line;

    rst_n = 1'b0;
    a_en = 1'b0; a_mode = 1'b0; a_sel_in = '0; a_sel_valid = 1'b0;
    b_en = 1'b0; b_mode = 1'b0; b_sel_in = '0; b_sel_valid = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_dec",   a_dec_out,   0);
    check("rst_valid", a_out_valid, 0);
    check("rst_cur",   a_cur_sel,   0);
    check("rst_wrap",  a_wrap,      0);
    check("rst_ready_en0", a_sel_ready, 0);
    rst_n = 1'b1;
    tick();
    check("idle_dec", a_dec_out, 0);

    // ---- direct decode: sel_in=2, then held for 10 cycles ----
    a_en = 1'b1; a_mode = 1'b0; a_sel_in = 2'd2; a_sel_valid = 1'b1;
    #1;
    check("dir_ready", a_sel_ready, 1);
    tick();
    a_sel_valid = 1'b0;
    check("dir2_dec",   a_dec_out,   4'b0100);
    check("dir2_cur",   a_cur_sel,   2);
    check("dir2_valid", a_out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_dec", a_dec_out, 4'b0100);
    end

    // ---- back-to-back transfers: 3 then 0 ----
    a_sel_in = 2'd3; a_sel_valid = 1'b1;
    tick();
    check("b2b3_dec", a_dec_out, 4'b1000);
    check("b2b3_cur", a_cur_sel, 3);
    a_sel_in = 2'd0;
    tick();
    check("b2b0_dec", a_dec_out, 4'b0001);
    check("b2b0_cur", a_cur_sel, 0);
    a_sel_valid = 1'b0;

    // ---- back to IDLE, then scan from IDLE ----
    a_en = 1'b0;
    tick();
    check("dis_dec",   a_dec_out,   0);
    check("dis_valid", a_out_valid, 0);
    a_en = 1'b1; a_mode = 1'b1;
    #1;
    check("scan_ready_pre", a_sel_ready, 0);
    // Cycle k after entry shows line (k/3)%4; wrap only at k=12.
    for (int k = 0; k <= 18; k++) begin
      tick();
      line = (k / 3) % 4;
      check("scan_dec",   a_dec_out,   32'(1) << line);
      check("scan_cur",   a_cur_sel,   line);
      check("scan_wrap",  a_wrap,      (k == 12) ? 1 : 0);
      check("scan_ready", a_sel_ready, 0);
      check("scan_valid", a_out_valid, 1);
    end

    // ---- mode 1->0 while on line 2 ----
    a_mode = 1'b0;
    #1;
    check("msw_ready_same", a_sel_ready, 0);
    tick();
    check("msw_dec",   a_dec_out,   4'b0100);
    check("msw_cur",   a_cur_sel,   2);
    check("msw_wrap",  a_wrap,      0);
    check("msw_ready", a_sel_ready, 1);
    tick();
    check("msw_frozen", a_dec_out, 4'b0100);
    a_sel_in = 2'd1; a_sel_valid = 1'b1;
    tick();
    a_sel_valid = 1'b0;
    check("msw_xfer_dec", a_dec_out, 4'b0010);
    check("msw_xfer_cur", a_cur_sel, 1);

    // ---- enable priority: en=0 together with sel_valid, sel_in=3 ----
    a_en = 1'b0; a_sel_in = 2'd3; a_sel_valid = 1'b1;
    #1;
    check("enp_ready", a_sel_ready, 0);
    tick();
    check("enp_dec",   a_dec_out,   0);
    check("enp_valid", a_out_valid, 0);
    check("enp_cur",   a_cur_sel,   1);
    tick();
    check("enp_cur2", a_cur_sel, 1);
    a_sel_valid = 1'b0;

    // ---- en returns with mode=1: scan restarts at line 0 ----
    a_en = 1'b1; a_mode = 1'b1;
    tick();
    check("rest_dec",  a_dec_out, 4'b0001);
    check("rest_cur",  a_cur_sel, 0);
    check("rest_wrap", a_wrap,    0);
    tick();
    tick();
    tick();
    check("rest_line1", a_dec_out, 4'b0010);

    // ---- asynchronous reset mid-cycle, en=1 mode=1 ----
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dec",   a_dec_out,   0);
    check("arst_valid", a_out_valid, 0);
    check("arst_cur",   a_cur_sel,   0);
    check("arst_wrap",  a_wrap,      0);
    a_mode = 1'b0; a_sel_in = 2'd3; a_sel_valid = 1'b1;
    tick();
    check("arst_hold_dec", a_dec_out, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_dec", a_dec_out, 4'b1000);
    check("post_rst_cur", a_cur_sel, 3);
    a_sel_valid = 1'b0; a_en = 1'b0;

    // ---- width sweep on instance B: 16 lines, one per cycle ----
    b_en = 1'b1; b_mode = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      tick();
      check("sw_dec",    b_dec_out,      32'(1) << (k % 16));
      check("sw_cur",    b_cur_sel,      k % 16);
      check("sw_wrap",   b_wrap,         (k > 0 && k % 16 == 0) ? 1 : 0);
      check("sw_onehot", $onehot(b_dec_out), 1);
    end
    b_en = 1'b0;
    tick();
    check("sw_dis_dec", b_dec_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_seq_nx2n.md
Name: decoder_seq_nx2n

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with enable and a valid/ready selection input.
- Adds an autonomous scan mode that walks the one-hot output through every line with a programmable dwell time and wrap indication.
- Drives row/column strobes and chip-select fans in the datapath, replacing single-width combinational decoders where a registered, glitch-free select is required.

Parameters:
- SEL_W, 2, select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable).
- DWELL, 4, clock cycles each output line is held in scan mode; legal range 1..65535, 0 is illegal (elaboration error).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; low forces outputs inactive.
- mode  input  1  0 = direct decode, 1 = scan.
- sel_in  input  SEL_W  selection index for direct decode.
- sel_valid  input  1  sel_in is valid.
- sel_ready  output  1  block accepts sel_in this cycle.
- dec_out  output  OUT_W  registered one-hot output; bit i high means line i is selected.
- out_valid  output  1  dec_out holds a valid selection.
- cur_sel  output  SEL_W  binary index of the currently or last selected line.
- wrap  output  1  one-cycle pulse when scan returns from line OUT_W-1 to line 0.

Behaviour:
- Clock, reset and state:
  - One clock; reset is asynchronous and active-low (rst_n, clk).
  - Reset values: dec_out=0, out_valid=0, cur_sel=0, wrap=0, dwell counter=0, state=IDLE.
- Decode mapping: standard, dec_out[i] = (index == i). At most one bit of dec_out is high in any cycle.
- State machine (registered):
  - IDLE: no output. Waits for en=1.
  - HOLD: direct-decode output held.
  - SCAN: auto-walk active.
- sel_ready = en & ~mode & (state != SCAN), combinational.
  - sel_ready is independent of sel_valid.
  - sel_ready is 0 while in SCAN even if mode has just dropped; it rises the cycle after the block leaves SCAN.
- Direct decode (transfer = sel_valid & sel_ready):
  - The cycle after a transfer: dec_out = 1 << sel_in, cur_sel = sel_in, out_valid = 1, state = HOLD. Latency is 1 clock.
  - In HOLD the output is held indefinitely until the next transfer, en=0, or mode=1.
  - Back-to-back transfers update the output every cycle.
- Scan entry:
  - Condition: en=1 and mode=1 while in IDLE or HOLD.
  - Next cycle: state = SCAN, cur_sel = 0, dec_out = 1, out_valid = 1, dwell counter = 0.
- Scan progression:
  - The counter increments each cycle. When it reaches DWELL-1 it clears and cur_sel increments the next cycle.
  - Each line is therefore high for exactly DWELL cycles.
  - cur_sel wraps from OUT_W-1 to 0. wrap = 1 for exactly the first cycle line 0 is reasserted after a wrap; wrap is not asserted on initial scan entry.
  - DWELL = 1 advances the line every cycle.
- mode 1->0 during SCAN:
  - Next cycle: state = HOLD; current dec_out and cur_sel are frozen; dwell counter clears; wrap = 0.
  - sel_ready asserts that same cycle.
- en = 0 (any state):
  - Next cycle: dec_out = 0, out_valid = 0, wrap = 0, state = IDLE, dwell counter clears; cur_sel retains its value.
  - en has priority over mode, sel_valid and scan advance when they occur in the same cycle.
  - A sel_valid presented with en=0 is not accepted (sel_ready=0).
  - When en returns with mode=1, the scan restarts at line 0.
- Reset mid-operation: outputs go to reset values immediately and asynchronously. The first possible transfer is on the first rising clk edge after rst_n rises.
- Width rules:
  - Dwell counter is $clog2(DWELL) bits, minimum 1.
  - cur_sel arithmetic is modulo 2**SEL_W; no extra wrap logic beyond natural overflow.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with en=1, mode=1 -> dec_out=0, out_valid=0, cur_sel=0, wrap=0 without a clock edge.
- Direct decode, SEL_W=2: en=1, mode=0, sel_in=2, sel_valid=1 for one cycle -> next cycle dec_out=4'b0100, cur_sel=2, out_valid=1; held 10 cycles with sel_valid=0. Then sel_in=3, 0 back-to-back -> 4'b1000 then 4'b0001 on consecutive cycles.
- Scan, SEL_W=2, DWELL=3: en=1, mode=1 from IDLE -> dec_out sequence 0001x3, 0010x3, 0100x3, 1000x3, 0001. wrap=1 only on the first cycle of the second 0001; sel_ready=0 throughout.
- Mode switch: during scan at line 2, drop mode -> next cycle dec_out=4'b0100 frozen, sel_ready=1. Then sel_in=1 transfer -> 4'b0010.
- Enable priority: en=0 in the same cycle as sel_valid=1 with sel_in=3 -> next cycle dec_out=0, out_valid=0, cur_sel unchanged, no transfer.
- Width sweep, SEL_W=4, DWELL=1: scan -> 16 distinct one-hot values, one per cycle; wrap every 16 cycles; one-hot checked each cycle by assertion.
